// File: rtl/exponential_pkg.sv
// Shared bfloat16 types, constants and rounding helper for the exponential unit.
// Macro LAMPFPU_EXP_RND_MODES_EN enables directed rounding modes in the consumers.
package exponential_pkg;

  localparam int LAMP_FLOAT_MUL_E_DW = 8;
  localparam int LAMP_FLOAT_MUL_F_DW = 7;

  typedef enum logic [1:0] {
    RNE = 2'd0,
    RTZ = 2'd1,
    RUP = 2'd2,
    RDN = 2'd3
  } rndMode_t;

  // Exponent/fraction fields only; bit 15 is replaced by the result sign.
  localparam logic [15:0] BF16_INF_E_F  = 16'h7F80;
  localparam logic [15:0] BF16_MAXF_E_F = 16'h7F7F;

  function automatic logic FUNC_rndUp(input rndMode_t mode, input logic s, input logic lsb,
                                      input logic g, input logic rs);
    logic roundUp;
    case (mode)
      RNE:     roundUp = g & (rs | lsb);
      RTZ:     roundUp = 1'b0;
      RUP:     roundUp = ~s & (g | rs);
      RDN:     roundUp = s & (g | rs);
      default: roundUp = 1'b0;
    endcase
    return roundUp;
  endfunction

endpackage

// File: rtl/lampfpu_exp_rnd_pack_decide.sv
// Combinational round-up / inexact decision from the low fraction bits.
// Rounding is suppressed when the multiplier marks the result as pre-encoded.
module lampfpu_exp_rnd_decide
  import exponential_pkg::*;
(
  input  rndMode_t   rndMode_i,
  input  logic       s_i,
  input  logic [3:0] lgrs_i,
  input  logic       isToRound_i,
  output logic       roundUp_o,
  output logic       inexact_o
);

  logic lsb;
  logic g;
  logic rs;

  assign lsb       = lgrs_i[3];
  assign g         = lgrs_i[2];
  assign rs        = lgrs_i[1] | lgrs_i[0];
  assign inexact_o = g | rs;
  assign roundUp_o = isToRound_i & FUNC_rndUp(rndMode_i, s_i, lsb, g, rs);

endmodule

// File: rtl/lampfpu_exp_rnd_pack.sv
// Two-stage round/pack of the unrounded bfloat16 multiplier result with sticky flags.
// Macro LAMPFPU_EXP_RND_MODES_EN adds rndMode_i and directed rounding modes.
module lampfpu_exp_rnd_pack
  import exponential_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        doRound_i,
  output logic        ready_o,
  input  logic        s_i,
  input  logic [7:0]  e_i,
  input  logic [11:0] f_i,
  input  logic        isOverflow_i,
  input  logic        isUnderflow_i,
  input  logic        isToRound_i,
`ifdef LAMPFPU_EXP_RND_MODES_EN
  input  logic [1:0]  rndMode_i,
`endif
  output logic [15:0] res_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        ovf_o,
  output logic        unf_o,
  output logic        inx_o,
  output logic [2:0]  flagsSticky_o,
  input  logic        flagsClr_i
);

  // Handshake: an input is taken on a clock edge where doRound_i & ready_o; a result
  // leaves on an edge where valid_o & ready_i. Both stages shift together only when
  // stage 2 is empty or draining, otherwise everything holds and inputs are dropped.
  logic       advance;
  logic       s1Valid, s1S, s1Inx, s1Ovf, s1Unf, s1ToRound;
  logic [7:0] s1E;
  logic [8:0] s1Sum;
  rndMode_t   mode, s1Mode;
  logic       roundUp, inexact;

`ifdef LAMPFPU_EXP_RND_MODES_EN
  assign mode = rndMode_t'(rndMode_i);
`else
  assign mode = RNE;
`endif

  lampfpu_exp_rnd_decide u_decide (
    .rndMode_i   (mode),
    .s_i         (s_i),
    .lgrs_i      (f_i[3:0]),
    .isToRound_i (isToRound_i),
    .roundUp_o   (roundUp),
    .inexact_o   (inexact)
  );

  assign advance = ~valid_o | ready_i;
  assign ready_o = advance;

  // Saturate to max finite when the rounding direction points back toward zero.
  logic        satMax;
  logic [15:0] ovfWord;
  logic [7:0]  eInc;
  logic [15:0] nxtRes;
  logic        nxtOvf, nxtUnf, nxtInx;

`ifdef LAMPFPU_EXP_RND_MODES_EN
  assign satMax = (s1Mode == RTZ) | ((s1Mode == RUP) & s1S) | ((s1Mode == RDN) & ~s1S);
`else
  assign satMax = 1'b0;
`endif

  assign ovfWord = satMax ? {s1S, BF16_MAXF_E_F[14:0]} : {s1S, BF16_INF_E_F[14:0]};
  assign eInc    = s1E + 8'd1;

  always_comb begin
    nxtRes = {s1S, s1E, s1Sum[6:0]};
    nxtOvf = 1'b0;
    nxtInx = s1Inx & s1ToRound;
    nxtUnf = s1Unf & s1Inx;
    if (s1ToRound) begin
      if (s1Ovf) begin
        nxtRes = ovfWord;
        nxtOvf = 1'b1;
        nxtInx = 1'b1;
      end else if (s1Sum[8]) begin
        if (eInc == 8'hFF) begin
          nxtRes = ovfWord;
          nxtOvf = 1'b1;
          nxtInx = 1'b1;
        end else begin
          nxtRes = {s1S, eInc, 7'h0};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1Valid       <= 1'b0;
      s1S           <= 1'b0;
      s1E           <= 8'h0;
      s1Sum         <= 9'h0;
      s1Inx         <= 1'b0;
      s1Ovf         <= 1'b0;
      s1Unf         <= 1'b0;
      s1ToRound     <= 1'b0;
      s1Mode        <= RNE;
      valid_o       <= 1'b0;
      res_o         <= 16'h0;
      ovf_o         <= 1'b0;
      unf_o         <= 1'b0;
      inx_o         <= 1'b0;
      flagsSticky_o <= 3'b000;
    end else begin
      if (advance) begin
        s1Valid <= doRound_i;
        if (doRound_i) begin
          s1S       <= s_i;
          s1E       <= e_i;
          s1Sum     <= {1'b0, f_i[10:3]} + {8'h0, roundUp};
          s1Inx     <= inexact;
          s1Ovf     <= isOverflow_i;
          s1Unf     <= isUnderflow_i;
          s1ToRound <= isToRound_i;
          s1Mode    <= mode;
        end
        valid_o <= s1Valid;
        if (s1Valid) begin
          res_o <= nxtRes;
          ovf_o <= nxtOvf;
          unf_o <= nxtUnf;
          inx_o <= nxtInx;
        end
      end
      flagsSticky_o <= (flagsClr_i ? 3'b000 : flagsSticky_o)
                     | ((valid_o & ready_i) ? {ovf_o, unf_o, inx_o} : 3'b000);
    end
  end

endmodule

// File: tb/tb_lampfpu_exp_rnd_pack.sv
// Directed bench for lampfpu_exp_rnd_pack: rounding, carry, overflow, backpressure, sticky, reset.
module tb_lampfpu_exp_rnd_pack;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        doRound_i = 1'b0;
  logic        ready_o;
  logic        s_i = 1'b0;
  logic [7:0]  e_i = 8'h0;
  logic [11:0] f_i = 12'h0;
  logic        isOverflow_i = 1'b0;
  logic        isUnderflow_i = 1'b0;
  logic        isToRound_i = 1'b0;
`ifdef LAMPFPU_EXP_RND_MODES_EN
  logic [1:0]  rndMode_i = 2'd0;
`endif
  logic [15:0] res_o;
  logic        valid_o;
  logic        ready_i = 1'b1;
  logic        ovf_o, unf_o, inx_o;
  logic [2:0]  flagsSticky_o;
  logic        flagsClr_i = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lampfpu_exp_rnd_pack dut (
    .clk           (clk),
    .rst           (rst),
    .doRound_i     (doRound_i),
    .ready_o       (ready_o),
    .s_i           (s_i),
    .e_i           (e_i),
    .f_i           (f_i),
    .isOverflow_i  (isOverflow_i),
    .isUnderflow_i (isUnderflow_i),
    .isToRound_i   (isToRound_i),
`ifdef LAMPFPU_EXP_RND_MODES_EN
    .rndMode_i     (rndMode_i),
`endif
    .res_o         (res_o),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .ovf_o         (ovf_o),
    .unf_o         (unf_o),
    .inx_o         (inx_o),
    .flagsSticky_o (flagsSticky_o),
    .flagsClr_i    (flagsClr_i)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one input on the next edge; upstream must only issue while ready_o is high.
  task automatic issue(input logic s, input logic [7:0] e, input logic [11:0] f,
                       input logic tr, input logic ov, input logic un);
    chk("ready_before_issue", {15'h0, ready_o}, 16'h1);
    s_i = s; e_i = e; f_i = f;
    isToRound_i = tr; isOverflow_i = ov; isUnderflow_i = un;
    doRound_i = 1'b1;
    tick();
    doRound_i = 1'b0;
  endtask

  // One edge after issue the result must be on the output; checks word and flags.
  task automatic expect_res(input string tag, input logic [15:0] res,
                            input logic ovf, input logic unf, input logic inx);
    chk({tag, "_not_early"}, {15'h0, valid_o}, 16'h0);
    tick();
    chk({tag, "_valid"}, {15'h0, valid_o}, 16'h1);
    chk({tag, "_res"}, res_o, res);
    chk({tag, "_flags"}, {13'h0, ovf_o, unf_o, inx_o}, {13'h0, ovf, unf, inx});
  endtask

  initial begin
    // Reset
    tick();
    tick();
    chk("rst_valid", {15'h0, valid_o}, 16'h0);
    chk("rst_res", res_o, 16'h0);
    chk("rst_sticky", {13'h0, flagsSticky_o}, 16'h0);
    rst = 1'b1;
    tick();
    chk("rst_ready", {15'h0, ready_o}, 16'h1);

    // Basic rounding cases, one at a time with ready_i high
    issue(1'b0, 8'h7F, 12'h400, 1'b1, 1'b0, 1'b0);
    expect_res("one", 16'h3F80, 1'b0, 1'b0, 1'b0);
    issue(1'b0, 8'h7F, 12'h40C, 1'b1, 1'b0, 1'b0);
    expect_res("rne_up", 16'h3F82, 1'b0, 1'b0, 1'b1);
    issue(1'b0, 8'h7F, 12'h404, 1'b1, 1'b0, 1'b0);
    expect_res("rne_tie_even", 16'h3F80, 1'b0, 1'b0, 1'b1);
    issue(1'b0, 8'h7F, 12'h7FC, 1'b1, 1'b0, 1'b0);
    expect_res("carry", 16'h4000, 1'b0, 1'b0, 1'b1);
    issue(1'b0, 8'hFE, 12'h7FC, 1'b1, 1'b0, 1'b0);
    expect_res("carry_ovf", 16'h7F80, 1'b1, 1'b0, 1'b1);
    tick();
    chk("sticky_ovf_inx", {13'h0, flagsSticky_o}, 16'h5);

    // Pre-encoded NaN passes through untouched
    issue(1'b0, 8'hFF, 12'h600, 1'b0, 1'b0, 1'b0);
    expect_res("nan_pass", 16'h7FC0, 1'b0, 1'b0, 1'b0);
    // Multiplier overflow flag, negative sign
    issue(1'b1, 8'h10, 12'h400, 1'b1, 1'b1, 1'b0);
    expect_res("mul_ovf", 16'hFF80, 1'b1, 1'b0, 1'b1);
    tick();

    // Backpressure: two back-to-back results held while ready_i is low
    ready_i = 1'b0;
    issue(1'b0, 8'h40, 12'h400, 1'b1, 1'b0, 1'b0);
    issue(1'b1, 8'h41, 12'h408, 1'b1, 1'b0, 1'b0);
    chk("bp_valid", {15'h0, valid_o}, 16'h1);
    chk("bp_ready_low", {15'h0, ready_o}, 16'h0);
    chk("bp_res_a", res_o, 16'h2000);
    tick();
    tick();
    chk("bp_res_a_stable", res_o, 16'h2000);
    chk("bp_ready_still_low", {15'h0, ready_o}, 16'h0);
    ready_i = 1'b1;
    #1;
    chk("bp_ready_release", {15'h0, ready_o}, 16'h1);
    tick();
    chk("bp_valid_b", {15'h0, valid_o}, 16'h1);
    chk("bp_res_b", res_o, 16'hA081);
    tick();
    chk("bp_drained", {15'h0, valid_o}, 16'h0);
    chk("bp_sticky_unchanged", {13'h0, flagsSticky_o}, 16'h5);

    // Clear sticky in the same cycle an inexact result is accepted
    issue(1'b0, 8'h7F, 12'h40C, 1'b1, 1'b0, 1'b0);
    expect_res("clr_vec", 16'h3F82, 1'b0, 1'b0, 1'b1);
    flagsClr_i = 1'b1;
    tick();
    flagsClr_i = 1'b0;
    chk("sticky_clr_set", {13'h0, flagsSticky_o}, 16'h1);

    // Underflow with inexact
    issue(1'b0, 8'h01, 12'h404, 1'b1, 1'b0, 1'b1);
    expect_res("unf", 16'h0080, 1'b0, 1'b1, 1'b1);
    tick();
    chk("sticky_unf", {13'h0, flagsSticky_o}, 16'h3);

`ifdef LAMPFPU_EXP_RND_MODES_EN
    rndMode_i = 2'd1;
    issue(1'b0, 8'hFE, 12'h7FC, 1'b1, 1'b0, 1'b0);
    expect_res("rtz_no_carry", 16'h7F7F, 1'b0, 1'b0, 1'b1);
    issue(1'b0, 8'h10, 12'h400, 1'b1, 1'b1, 1'b0);
    expect_res("rtz_ovf_sat", 16'h7F7F, 1'b1, 1'b0, 1'b1);
    rndMode_i = 2'd3;
    issue(1'b1, 8'h7F, 12'h401, 1'b1, 1'b0, 1'b0);
    expect_res("rdn_neg_up", 16'hBF81, 1'b0, 1'b0, 1'b1);
    rndMode_i = 2'd0;
    tick();
`endif

    // Asynchronous reset mid-stream discards in-flight results
    issue(1'b0, 8'h7F, 12'h40C, 1'b1, 1'b0, 1'b0);
    tick();
    chk("pre_rst_valid", {15'h0, valid_o}, 16'h1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_valid", {15'h0, valid_o}, 16'h0);
    chk("async_rst_res", res_o, 16'h0);
    chk("async_rst_sticky", {13'h0, flagsSticky_o}, 16'h0);
    tick();
    rst = 1'b1;
    tick();
    tick();
    chk("post_rst_no_ghost", {15'h0, valid_o}, 16'h0);
    chk("post_rst_ready", {15'h0, ready_o}, 16'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lampfpu_exp_rnd_pack.md
# lampfpu_exp_rnd_pack

- Consumer-side end of the bfloat16 multiplier interface inside the exponential unit.
- Takes the registered unrounded multiplier output: sign, 8-bit exponent, 12-bit extended fraction with G/R/S, and the overflow/underflow/to-round flags.
- Rounds, handles mantissa carry and exponent overflow, and packs a 16-bit bfloat16 word.
- Two-stage pipeline with valid/ready backpressure toward the downstream consumer, plus sticky IEEE exception flags.

## Interface
Parameters
- LAMP_FLOAT_MUL_E_DW, 8, exponent width (from exponential_pkg)
- LAMP_FLOAT_MUL_F_DW, 7, stored fraction width (from exponential_pkg)

Ports
- clk  in  1  clock; all state on posedge
- rst  in  1  asynchronous, active-low reset
- doRound_i  in  1  input valid (driven by multiplier valid_o)
- ready_o  out  1  block can accept input this cycle
- s_i  in  1  result sign
- e_i  in  8  result exponent
- f_i  in  12  {ovf bit[11], hidden[10], frac[9:3], G[2], R[1], S[0]}
- isOverflow_i / isUnderflow_i / isToRound_i  in  1 each  multiplier flags
- rndMode_i  in  2  0 RNE, 1 RTZ, 2 RUP, 3 RDN (present only with macro)
- res_o  out  16  packed {s, e[7:0], frac[6:0]}
- valid_o  out  1  res_o/flags valid
- ready_i  in  1  downstream accepts
- ovf_o, unf_o, inx_o  out  1 each  per-result flags
- flagsSticky_o  out  3  {ovf, unf, inx} accumulated
- flagsClr_i  in  1  clear sticky flags

## Operation
- Stage 1 (capture on doRound_i & ready_o):
  - lsb=f_i[3], G=f_i[2], RS=f_i[1]|f_i[0], inexact=G|RS.
  - RNE roundUp = G & (RS | lsb).
  - Register s, e, 9-bit sum {1'b0, f_i[10:3]} + roundUp, inexact, and the flags.
- Stage 2 (registered pack):
  - isToRound=0: res = {s, e, f[9:3]}, no rounding applied; covers zero, inf and NaN, which the multiplier pre-encodes. inx_o=0.
  - isOverflow_i=1: res = {s, 8'hFF, 7'h0}, ovf_o=1, inx_o=1.
  - Sum bit 8 set (mantissa carry): frac=0, e+1. If e+1==8'hFF: res={s,8'hFF,0}, ovf_o=1.
  - Otherwise res = {s, e, sum[6:0]}.
  - unf_o = isUnderflow_i & inexact.
- Sticky flags: flagsSticky_q <= (flagsClr_i ? 0 : flagsSticky_q) | (accepted-output flags). A set and a clear in the same cycle leave the new flag set.
- Flags accumulate on the output handshake only (valid_o & ready_i).
- Input values when doRound_i=0 are ignored.

## Timing
- Latency 2 cycles, doRound_i accept to valid_o.
- Throughput 1 result per cycle while ready_i=1.
- Backpressure:
  - ready_o = ~s2_valid | ready_i.
  - Stage 1 advances into stage 2 only when stage 2 is empty or draining.
  - When stalled, both stages hold; res_o and flags stay stable while valid_o=1 & ready_i=0.
- The multiplier has no ready input, so upstream must only issue when ready_o=1. Issuing while ready_o=0 drops the input; the bench flags this as an error.
- Reset (asynchronous assert, synchronous release): all outputs and state are 0, including res_o=16'h0, valid_o=0, flags=0. ready_o=1 in the first cycle after release.
- Reset mid-operation discards both in-flight results.

## Configuration
- LAMPFPU_EXP_RND_MODES_EN defined:
  - rndMode_i port exists and is sampled in stage 1.
  - RTZ roundUp=0; RUP roundUp=~s&inexact; RDN roundUp=s&inexact.
  - Overflow under RTZ, or under the away-from-sign directed mode, yields max finite {s,8'hFE,7'h7F} instead of inf.
  - rndMode 3 is RDN.
- Undefined: port absent, RNE only, overflow always yields inf.

## Structure
- Add to exponential_pkg:
  - rounding mode enum (RNE, RTZ, RUP, RDN).
  - 16-bit constants BF16_INF_E_F and BF16_MAXF_E_F.
  - FUNC_rndUp(mode, s, lsb, G, RS) returning roundUp.
- One natural sub-module: lampfpu_exp_rnd_decide, purely combinational, computing roundUp and inexact. The pipeline registers and sticky logic stay in the top module.

## Test plan
- e=0x7F, f=0x400, isToRound=1 -> res 0x3F80, inx=0, valid_o exactly 2 cycles after accept.
- e=0x7F, f=0x40C (lsb=1, G=1) -> res 0x3F82, inx=1. f=0x404 (lsb=0, G=1, tie) -> 0x3F80, inx=1.
- e=0x7F, f=0x7FC -> carry, res 0x4000. e=0xFE, f=0x7FC -> res 0x7F80, ovf_o=1, flagsSticky_o=3'b101.
- isToRound=0, e=0xFF, f=0x600 -> res 0x7FC0 unchanged, inx=0.
- Back-to-back inputs with ready_i low for 3 cycles -> ready_o drops after 2 held results, res_o stable, no loss, order preserved. Then flagsClr_i together with a new inexact result -> sticky=3'b001.
- Assert rst low mid-stream -> valid_o=0, res_o=0, sticky=0 immediately (asynchronous). With macro: RTZ on the overflow case -> 0x7F7F.
